// File: rtl/pll_lock_reset_pkg.sv
// Shared types and parameter checks for the PLL lock / system reset sequencer.
package pll_lock_reset_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

  // The phase counter only ever reaches (cycles - 1), so it must represent max - 1.
  function automatic bit params_ok(
    input int sync_stages,
    input int pll_rst_cycles,
    input int lock_timeout,
    input int lock_stable_cycles,
    input int reset_hold_cycles,
    input int cnt_w,
    input int stat_w
  );
    longint max_cycles;
    max_cycles = longint'(pll_rst_cycles);
    if (lock_timeout > max_cycles) max_cycles = longint'(lock_timeout);
    else max_cycles = max_cycles;
    if (lock_stable_cycles > max_cycles) max_cycles = longint'(lock_stable_cycles);
    else max_cycles = max_cycles;
    if (reset_hold_cycles > max_cycles) max_cycles = longint'(reset_hold_cycles);
    else max_cycles = max_cycles;
    return (sync_stages >= 2) && (pll_rst_cycles >= 1) && (lock_timeout >= 1) &&
           (lock_stable_cycles >= 1) && (reset_hold_cycles >= 1) &&
           (cnt_w >= 1) && (cnt_w <= 32) && (stat_w >= 1) &&
           (max_cycles <= (64'sd1 <<< cnt_w));
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-stage flop synchronizer for a single asynchronous level signal.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the sampled level through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_chain <= {STAGES{1'b0}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL reset / lock qualification sequencer producing a held, synchronous system reset
// plus saturating lock-loss and lock-timeout status counters.
module pll_lock_reset_seq
  import pll_lock_reset_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 32,
  parameter int CNT_W              = 16,
  parameter int STAT_W             = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              locked_in,
  input  logic              soft_reset_req,
  output logic              pll_rst,
  output logic              sys_reset_n,
  output logic              ready,
  output logic [STAT_W-1:0] lock_loss_count,
  output logic [STAT_W-1:0] timeout_count
);

  if (!params_ok(SYNC_STAGES, PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES,
                 RESET_HOLD_CYCLES, CNT_W, STAT_W)) begin : g_param_check
    $error("pll_lock_reset_seq: illegal parameter set");
  end

  localparam logic [CNT_W-1:0]  PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [STAT_W-1:0] STAT_MAX     = {STAT_W{1'b1}};

  logic              w_locked_sync;
  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_timeout_evt;
  logic              w_loss_evt;
  logic              w_pll_rst_nxt;
  logic              w_sys_reset_n_nxt;
  logic              w_ready_nxt;
  logic [STAT_W-1:0] w_loss_cnt_nxt;
  logic [STAT_W-1:0] w_timeout_cnt_nxt;
  logic              r_pll_rst;
  logic              r_sys_reset_n;
  logic              r_ready;
  logic [STAT_W-1:0] r_loss_cnt;
  logic [STAT_W-1:0] r_timeout_cnt;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (locked_in),
    .o_q     (w_locked_sync)
  );

  // Next-state decode; soft reset overrides everything except an ongoing PLL reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_evt = 1'b0;
    w_loss_evt    = 1'b0;
    if (soft_reset_req && (r_state != PLL_RST)) begin
      w_state_nxt = PLL_RST;
    end else begin
      case (r_state)
        PLL_RST: begin
          if (r_cnt == PLL_RST_LAST) w_state_nxt = WAIT_LOCK;
          else                       w_state_nxt = PLL_RST;
        end
        WAIT_LOCK: begin
          if (w_locked_sync) begin
            w_state_nxt = STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_state_nxt   = PLL_RST;
            w_timeout_evt = 1'b1;
          end else begin
            w_state_nxt = WAIT_LOCK;
          end
        end
        STABLE: begin
          if (!w_locked_sync)              w_state_nxt = WAIT_LOCK;
          else if (r_cnt == STABLE_LAST)   w_state_nxt = HOLD;
          else                             w_state_nxt = STABLE;
        end
        HOLD: begin
          if (!w_locked_sync)              w_state_nxt = WAIT_LOCK;
          else if (r_cnt == HOLD_LAST)     w_state_nxt = RUN;
          else                             w_state_nxt = HOLD;
        end
        RUN: begin
          if (!w_locked_sync) begin
            w_state_nxt = PLL_RST;
            w_loss_evt  = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = PLL_RST;
      endcase
    end
    if (w_state_nxt != r_state) w_cnt_nxt = {CNT_W{1'b0}};
    else                        w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  // Outputs decoded from the next state so they switch on the same edge as the state.
  always_comb begin
    w_pll_rst_nxt     = 1'b1;
    w_sys_reset_n_nxt = 1'b0;
    w_ready_nxt       = 1'b0;
    case (w_state_nxt)
      PLL_RST: begin
        w_pll_rst_nxt = 1'b1;
      end
      WAIT_LOCK, STABLE, HOLD: begin
        w_pll_rst_nxt = 1'b0;
      end
      RUN: begin
        w_pll_rst_nxt     = 1'b0;
        w_sys_reset_n_nxt = 1'b1;
        w_ready_nxt       = 1'b1;
      end
      default: begin
        w_pll_rst_nxt = 1'b1;
      end
    endcase
    if (w_loss_evt && (r_loss_cnt != STAT_MAX)) w_loss_cnt_nxt = r_loss_cnt + STAT_W'(1);
    else                                        w_loss_cnt_nxt = r_loss_cnt;
    if (w_timeout_evt && (r_timeout_cnt != STAT_MAX)) w_timeout_cnt_nxt = r_timeout_cnt + STAT_W'(1);
    else                                              w_timeout_cnt_nxt = r_timeout_cnt;
  end

  // State, phase counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= PLL_RST;
      r_cnt         <= {CNT_W{1'b0}};
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_loss_cnt    <= {STAT_W{1'b0}};
      r_timeout_cnt <= {STAT_W{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_pll_rst     <= w_pll_rst_nxt;
      r_sys_reset_n <= w_sys_reset_n_nxt;
      r_ready       <= w_ready_nxt;
      r_loss_cnt    <= w_loss_cnt_nxt;
      r_timeout_cnt <= w_timeout_cnt_nxt;
    end
  end

  assign pll_rst         = r_pll_rst;
  assign sys_reset_n     = r_sys_reset_n;
  assign ready           = r_ready;
  assign lock_loss_count = r_loss_cnt;
  assign timeout_count   = r_timeout_cnt;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with reduced cycle parameters.
module tb_pll_lock_reset_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       locked_in;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic [1:0] lock_loss_count;
  logic [1:0] timeout_count;

  int checks = 0;
  int errors = 0;
  bit seen_pll;
  int n;
  int exp_tmo;

  always #5 clk = ~clk;

  pll_lock_reset_seq #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (20),
    .LOCK_STABLE_CYCLES (8),
    .RESET_HOLD_CYCLES  (4),
    .CNT_W              (16),
    .STAT_W             (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .locked_in       (locked_in),
    .soft_reset_req  (soft_reset_req),
    .pll_rst         (pll_rst),
    .sys_reset_n     (sys_reset_n),
    .ready           (ready),
    .lock_loss_count (lock_loss_count),
    .timeout_count   (timeout_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (pll_rst === 1'b1) seen_pll = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Samples with pll_rst high, counting the current one; ends on the first low sample.
  task automatic count_high(output int cnt);
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  task automatic count_low(output int cnt);
    cnt = 0;
    while (pll_rst === 1'b0 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  // Edges taken until ready is seen high (first edge after the call is edge 1).
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic chk_outs(input string tag, input logic p, input logic s, input logic r,
                          input int loss, input int tmo);
    chk({tag, "_pll_rst"}, pll_rst, p);
    chk({tag, "_sys_reset_n"}, sys_reset_n, s);
    chk({tag, "_ready"}, ready, r);
    chk({tag, "_lock_loss"}, lock_loss_count, loss);
    chk({tag, "_timeout"}, timeout_count, tmo);
  endtask

  initial begin
    seen_pll       = 1'b0;
    reset_n        = 1'b0;
    locked_in      = 1'b0;
    soft_reset_req = 1'b0;
    tick();
    tick();
    chk_outs("reset", 1'b1, 1'b0, 1'b0, 0, 0);

    // Nominal bring-up: lock rises 3 cycles after pll_rst falls.
    reset_n = 1'b1;
    count_high(n);
    chk("nom_pll_rst_len", n, 4);
    tick(); tick(); tick();
    locked_in = 1'b1;
    wait_ready(n);
    chk("nom_lock_to_ready_edges", n, 15);
    chk_outs("nom_run", 1'b0, 1'b1, 1'b1, 0, 0);

    // Lock loss in RUN: two edges of sync latency, then abort on the third.
    locked_in = 1'b0;
    tick(); tick();
    chk("loss_sync_latency_ready", ready, 1'b1);
    tick();
    chk_outs("loss_abort", 1'b1, 1'b0, 1'b0, 1, 0);
    locked_in = 1'b1;
    count_high(n);
    chk("loss_pll_rst_len", n, 4);
    wait_ready(n);
    chk("loss_reseq_edges", n, 13);

    // Soft reset in RUN.
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    chk_outs("soft_run", 1'b1, 1'b0, 1'b0, 1, 0);
    count_high(n);
    chk("soft_run_pll_rst_len", n, 4);
    repeat (10) tick();
    chk_outs("in_hold", 1'b0, 1'b0, 1'b0, 1, 0);
    // Soft reset in HOLD.
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    chk_outs("soft_hold", 1'b1, 1'b0, 1'b0, 1, 0);
    // Soft reset during PLL_RST must not stretch the pulse (2 samples already high).
    tick();
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    count_high(n);
    chk("soft_in_pll_rst_len", n + 2, 4);
    wait_ready(n);
    chk("soft_reseq_edges", n, 13);

    // Reset asserted for one cycle in HOLD.
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    count_high(n);
    repeat (10) tick();
    chk("pre_reset_hold_pll_rst", pll_rst, 1'b0);
    reset_n   = 1'b0;
    locked_in = 1'b0;
    tick();
    chk_outs("reset_mid_hold", 1'b1, 1'b0, 1'b0, 0, 0);
    reset_n = 1'b1;
    count_high(n);
    chk("post_reset_pll_rst_len", n, 4);

    // Unstable lock: 5 high, 2 low, then high again; qualification restarts.
    seen_pll  = 1'b0;
    locked_in = 1'b1;
    repeat (5) tick();
    locked_in = 1'b0;
    tick(); tick();
    locked_in = 1'b1;
    wait_ready(n);
    chk("unstable_second_rise_edges", n, 15);
    chk("unstable_no_pll_rst", seen_pll, 1'b0);
    chk_outs("unstable_run", 1'b0, 1'b1, 1'b1, 0, 0);

    // Timeout retry with lock held low; timeout_count saturates at 3.
    locked_in      = 1'b0;
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    chk_outs("tmo_start", 1'b1, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      count_high(n);
      chk($sformatf("tmo%0d_high_len", k), n, 4);
      count_low(n);
      chk($sformatf("tmo%0d_low_len", k), n, 20);
      exp_tmo = (k + 1 > 3) ? 3 : k + 1;
      chk($sformatf("tmo%0d_count", k), timeout_count, exp_tmo);
    end
    chk("tmo_lock_loss_unchanged", lock_loss_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
